// File: rtl/tb_mem_arb_if.sv
// Bundle of the two requester OBI ports and the shared downstream OBI port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface tb_mem_arb_if #(
   parameter int DW = 32
);
   logic          instr_req;
   logic [31:0]   instr_addr;
   logic          instr_gnt;
   logic          instr_rvalid;
   logic [DW-1:0] instr_rdata;
   logic          instr_err;

   logic          data_req;
   logic          data_we;
   logic [3:0]    data_be;
   logic [31:0]   data_addr;
   logic [DW-1:0] data_wdata;
   logic          data_gnt;
   logic          data_rvalid;
   logic [DW-1:0] data_rdata;
   logic          data_err;

   logic          mem_req;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [31:0]   mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic          mem_err;

   modport slave (
      input  instr_req, instr_addr,
      output instr_gnt, instr_rvalid, instr_rdata, instr_err,
      input  data_req, data_we, data_be, data_addr, data_wdata,
      output data_gnt, data_rvalid, data_rdata, data_err,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata, mem_err
   );

   modport master (
      output instr_req, instr_addr,
      input  instr_gnt, instr_rvalid, instr_rdata, instr_err,
      output data_req, data_we, data_be, data_addr, data_wdata,
      input  data_gnt, data_rvalid, data_rdata, data_err,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata, mem_err
   );
endinterface

// File: rtl/tb_mem_arb.sv
// Two-port OBI arbiter (instruction/data) onto one in-order memory port.
// Round-robin on ties, ownership lock while a request waits for gnt, ID FIFO for response routing.
module tb_mem_arb #(
   parameter int DW       = 32,
   parameter int MAX_OUTS = 4
) (
   input  logic            clk,
   input  logic            rst,
   tb_mem_arb_if.slave     bus,
   output logic            prot_err
);
   localparam int PW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTS);
   localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTS - 1);

   typedef enum logic {
      PORT_INSTR = 1'b0,
      PORT_DATA  = 1'b1
   } port_e;

   logic          lock_reg;
   port_e         lock_owner_reg;
   port_e         last_grant_reg;
   logic [CW-1:0] count_reg;
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic          prot_err_reg;
   port_e         id_fifo [MAX_OUTS];

   port_e         owner;
   port_e         head;
   logic          owner_req;
   logic          full;
   logic          any_out;
   logic          mem_req_int;
   logic          push;
   logic          pop;

   logic          mem_we_int;
   logic [3:0]    mem_be_int;
   logic [31:0]   mem_addr_int;
   logic [DW-1:0] mem_wdata_int;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // A locked owner keeps the bus until its pending request is granted.
   always_comb begin
      owner = PORT_INSTR;
      if (lock_reg)
         owner = lock_owner_reg;
      else if (bus.instr_req && bus.data_req)
         owner = (last_grant_reg == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
      else if (bus.data_req)
         owner = PORT_DATA;
   end

   assign owner_req   = (owner == PORT_DATA) ? bus.data_req : bus.instr_req;
   assign full        = (count_reg == FULL_CNT);
   assign any_out     = (count_reg != '0);
   assign mem_req_int = owner_req && !full && !rst;
   assign push        = mem_req_int && bus.mem_gnt;
   assign pop         = bus.mem_rvalid && any_out && !rst;
   assign head        = id_fifo[rd_ptr_reg];

   always_comb begin
      mem_we_int    = 1'b0;
      mem_be_int    = 4'h0;
      mem_addr_int  = 32'h0;
      mem_wdata_int = '0;
      if (!rst) begin
         if (owner == PORT_DATA) begin
            mem_we_int    = bus.data_we;
            mem_be_int    = bus.data_be;
            mem_addr_int  = bus.data_addr;
            mem_wdata_int = bus.data_wdata;
         end else begin
            mem_be_int    = 4'hf;
            mem_addr_int  = bus.instr_addr;
         end
      end
   end

   assign bus.mem_req      = mem_req_int;
   assign bus.mem_we       = mem_we_int;
   assign bus.mem_be       = mem_be_int;
   assign bus.mem_addr     = mem_addr_int;
   assign bus.mem_wdata    = mem_wdata_int;

   assign bus.instr_gnt    = push && (owner == PORT_INSTR);
   assign bus.data_gnt     = push && (owner == PORT_DATA);
   assign bus.instr_rvalid = pop && (head == PORT_INSTR);
   assign bus.data_rvalid  = pop && (head == PORT_DATA);
   assign bus.instr_err    = pop && (head == PORT_INSTR) && bus.mem_err;
   assign bus.data_err     = pop && (head == PORT_DATA) && bus.mem_err;
   assign bus.instr_rdata  = rst ? {DW{1'b0}} : bus.mem_rdata;
   assign bus.data_rdata   = rst ? {DW{1'b0}} : bus.mem_rdata;

   assign prot_err         = prot_err_reg;

   // ID storage needs no reset: entries are only read below a valid count.
   always_ff @(posedge clk) begin
      if (push)
         id_fifo[wr_ptr_reg] <= owner;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_reg       <= 1'b0;
         lock_owner_reg <= PORT_INSTR;
         last_grant_reg <= PORT_INSTR;
         count_reg      <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         prot_err_reg   <= 1'b0;
      end else begin
         if (push) begin
            lock_reg       <= 1'b0;
            last_grant_reg <= owner;
            wr_ptr_reg     <= ptr_next(wr_ptr_reg);
         end else if (mem_req_int) begin
            lock_reg       <= 1'b1;
            lock_owner_reg <= owner;
         end

         if (pop)
            rd_ptr_reg <= ptr_next(rd_ptr_reg);

         // A pop at full frees the slot only from the next cycle on.
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase

         if (bus.mem_rvalid && !any_out)
            prot_err_reg <= 1'b1;
      end
   end
endmodule

// File: tb/tb_tb_mem_arb.sv
// Directed bench for tb_mem_arb: expected port IDs are queued on each expected grant
// and popped to check response routing when the bench returns memory responses.
module tb_tb_mem_arb;
   localparam int DW = 32;
   localparam logic [31:0] IADDR  = 32'h0000_1000;
   localparam logic [31:0] DADDR  = 32'h2000_0040;
   localparam logic [31:0] DWDATA = 32'hCAFE_F00D;
   localparam logic [3:0]  DBE    = 4'h3;

   logic clk;
   logic rst;
   logic prot_err;
   int   tests_run;
   int   tests_failed;
   bit   exp_q [$];

   tb_mem_arb_if #(.DW(DW)) bus ();

   tb_mem_arb #(.DW(DW), .MAX_OUTS(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .prot_err (prot_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit ir, input bit dr, input bit g, input bit rv,
                        input logic [31:0] rd, input bit er);
      bus.instr_req  = ir;
      bus.data_req   = dr;
      bus.mem_gnt    = g;
      bus.mem_rvalid = rv;
      bus.mem_rdata  = rd;
      bus.mem_err    = er;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 32'h0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic expect_grant(input bit port);
      $display("[TB] grant expected to %s", port ? "data" : "instr");
      check("instr_gnt", 32'(bus.instr_gnt), 32'(port == 1'b0));
      check("data_gnt",  32'(bus.data_gnt),  32'(port == 1'b1));
      check("mem_req",   32'(bus.mem_req),   32'd1);
      check("mem_addr",  bus.mem_addr,       port ? DADDR : IADDR);
      check("mem_we",    32'(bus.mem_we),    32'(port));
      check("mem_be",    32'(bus.mem_be),    port ? 32'(DBE) : 32'hf);
      check("mem_wdata", bus.mem_wdata,      port ? DWDATA : 32'h0);
      exp_q.push_back(port);
   endtask

   task automatic expect_stall();
      $display("[TB] stall expected");
      check("stall_mem_req",   32'(bus.mem_req),   32'd0);
      check("stall_instr_gnt", 32'(bus.instr_gnt), 32'd0);
      check("stall_data_gnt",  32'(bus.data_gnt),  32'd0);
   endtask

   task automatic expect_resp(input logic [31:0] rd, input bit er);
      bit id;
      tests_run++;
      if (exp_q.size() == 0) begin
         tests_failed++;
         $display("FAIL resp_queue: observed empty scoreboard expected pending id");
      end else begin
         id = exp_q.pop_front();
         $display("[TB] response rdata=%08h err=%0d expected to %s", rd, er, id ? "data" : "instr");
         check("instr_rvalid", 32'(bus.instr_rvalid), 32'(id == 1'b0));
         check("data_rvalid",  32'(bus.data_rvalid),  32'(id == 1'b1));
         check("instr_err",    32'(bus.instr_err),    32'(!id && er));
         check("data_err",     32'(bus.data_err),     32'(id && er));
         check("instr_rdata",  bus.instr_rdata,       rd);
         check("data_rdata",   bus.data_rdata,        rd);
      end
   endtask

   task automatic expect_no_resp();
      $display("[TB] no port response expected");
      check("no_instr_rvalid", 32'(bus.instr_rvalid), 32'd0);
      check("no_data_rvalid",  32'(bus.data_rvalid),  32'd0);
   endtask

   task automatic expect_all_zero(input string tag);
      $display("[TB] %s: all outputs zero expected", tag);
      check({tag, "_mem_req"},      32'(bus.mem_req),      32'd0);
      check({tag, "_mem_addr"},     bus.mem_addr,          32'd0);
      check({tag, "_instr_gnt"},    32'(bus.instr_gnt),    32'd0);
      check({tag, "_data_gnt"},     32'(bus.data_gnt),     32'd0);
      check({tag, "_instr_rvalid"}, 32'(bus.instr_rvalid), 32'd0);
      check({tag, "_data_rvalid"},  32'(bus.data_rvalid),  32'd0);
      check({tag, "_instr_rdata"},  bus.instr_rdata,       32'd0);
      check({tag, "_prot_err"},     32'(prot_err),         32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      bus.instr_addr = IADDR;
      bus.data_addr  = DADDR;
      bus.data_we    = 1'b1;
      bus.data_be    = DBE;
      bus.data_wdata = DWDATA;

      // Reset holds every output low even with live inputs.
      rst = 1'b1;
      drive(1, 1, 1, 1, 32'h5555_AAAA, 1);
      sample();
      expect_all_zero("reset");
      do_reset();

      // Both requesting with mem_gnt high: data first, then alternating.
      drive(1, 1, 1, 0, 32'h0, 0);
      sample(); expect_grant(1); tick();
      sample(); expect_grant(0); tick();
      sample(); expect_grant(1); tick();
      sample(); expect_grant(0); tick();
      // Four outstanding: stall, one response frees a slot on the next cycle.
      drive(1, 1, 1, 1, 32'h1111_0001, 0);
      sample(); expect_stall(); expect_resp(32'h1111_0001, 0); tick();
      drive(1, 1, 1, 0, 32'h0, 0);
      sample(); expect_grant(1); tick();
      drive(0, 0, 0, 1, 32'h2222_0002, 1);
      sample(); expect_stall(); expect_resp(32'h2222_0002, 1); tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, 32'h3333_0000 + 32'(i), 0);
         sample(); expect_resp(32'h3333_0000 + 32'(i), 0); tick();
      end

      // Push and pop in the same cycle at count 2.
      drive(1, 0, 1, 0, 32'h0, 0);
      sample(); expect_grant(0); tick();
      drive(0, 1, 1, 0, 32'h0, 0);
      sample(); expect_grant(1); tick();
      drive(1, 0, 1, 1, 32'h4444_0004, 0);
      sample(); expect_resp(32'h4444_0004, 0); expect_grant(0); tick();
      drive(1, 1, 1, 0, 32'h0, 0);
      sample(); expect_grant(1); tick();
      sample(); expect_grant(0); tick();
      sample(); expect_stall(); tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 1, 32'h5555_0000 + 32'(i), 0);
         sample(); expect_resp(32'h5555_0000 + 32'(i), 0); tick();
      end

      // Response with nothing outstanding: dropped, sticky prot_err.
      drive(0, 0, 0, 1, 32'h6666_0006, 0);
      sample(); expect_no_resp(); check("prot_err_before", 32'(prot_err), 32'd0); tick();
      drive(0, 0, 0, 0, 32'h0, 0);
      sample(); check("prot_err_set", 32'(prot_err), 32'd1); tick();
      sample(); check("prot_err_sticky", 32'(prot_err), 32'd1);
      do_reset();
      sample(); check("prot_err_cleared", 32'(prot_err), 32'd0); tick();

      // Lock: instr keeps ownership through 3 cycles without gnt.
      drive(1, 0, 0, 0, 32'h0, 0);
      sample();
      check("lock0_mem_req", 32'(bus.mem_req), 32'd1);
      check("lock0_instr_gnt", 32'(bus.instr_gnt), 32'd0);
      check("lock0_mem_addr", bus.mem_addr, IADDR);
      tick();
      for (int i = 1; i < 3; i++) begin
         drive(1, 1, 0, 0, 32'h0, 0);
         sample();
         $display("[TB] lock cycle %0d: instr keeps ownership", i);
         check("lock_mem_addr", bus.mem_addr, IADDR);
         check("lock_mem_we", 32'(bus.mem_we), 32'd0);
         check("lock_data_gnt", 32'(bus.data_gnt), 32'd0);
         tick();
      end
      drive(1, 1, 1, 0, 32'h0, 0);
      sample(); expect_grant(0); tick();
      drive(0, 1, 1, 0, 32'h0, 0);
      sample(); expect_grant(1); tick();

      // Asynchronous reset with two outstanding, away from the clock edge.
      drive(1, 1, 1, 1, 32'h7777_0007, 0);
      #2 rst = 1'b1;
      #1 expect_all_zero("async_rst");
      exp_q.delete();
      @(posedge clk);
      #1 drive(0, 0, 0, 0, 32'h0, 0);
      #2 rst = 1'b0;
      sample(); check("post_rst_mem_req", 32'(bus.mem_req), 32'd0); tick();
      drive(0, 0, 0, 1, 32'h8888_0008, 0);
      sample(); expect_no_resp(); tick();
      drive(0, 0, 0, 0, 32'h0, 0);
      sample(); check("stale_resp_prot_err", 32'(prot_err), 32'd1);
      do_reset();

      // last_grant back to instr: data wins the first tie again.
      drive(1, 1, 1, 0, 32'h0, 0);
      sample(); expect_grant(1); tick();
      sample(); expect_grant(0); tick();
      drive(0, 0, 0, 1, 32'h9999_0009, 0);
      sample(); expect_resp(32'h9999_0009, 0); tick();
      drive(0, 0, 0, 1, 32'h9999_000A, 0);
      sample(); expect_resp(32'h9999_000A, 0); tick();
      drive(0, 0, 0, 0, 32'h0, 0);
      sample(); check("final_prot_err", 32'(prot_err), 32'd0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
